mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Parametrised N-channel arbiter sharing one RV32I-style memory port (read/write/byte_enable/resp).
//  Sits between CPU-side requesters (i-fetch, d-access, future cache/DMA) and the single memory port.
//  Grants one channel at a time, holds it until the memory pulses resp, then routes resp/rdata back.
//  Selectable fixed-priority or round-robin arbitration.
// PARAMETERS
//  NUM_CH    2   number of requester channels (>=2)
//  ADDR_W    32  address width
//  DATA_W    32  data width; byte enable width BE_W = DATA_W/8
//  ARB_MODE  0   0 = fixed priority (lowest index wins), 1 = round-robin
// PORTS
//  clk              in   1              rising-edge clock
//  rst              in   1              synchronous, active-high reset
//  ch_read          in   NUM_CH         per-channel read request (level, held until ch_resp)
//  ch_write         in   NUM_CH         per-channel write request (level, held until ch_resp)
//  ch_byte_enable   in   NUM_CH*BE_W    per-channel byte enables, channel k at [k*BE_W +: BE_W]
//  ch_address       in   NUM_CH*ADDR_W  per-channel address
//  ch_wdata         in   NUM_CH*DATA_W  per-channel write data
//  ch_resp          out  NUM_CH         one-hot, 1-cycle completion pulse to granted channel
//  ch_rdata         out  DATA_W         read data, valid when any ch_resp bit high
//  mem_read         out  1              memory read strobe
//  mem_write        out  1              memory write strobe
//  mem_byte_enable  out  BE_W           memory byte enables
//  mem_address      out  ADDR_W         memory address
//  mem_wdata        out  DATA_W         memory write data
//  mem_resp         in   1              memory completion pulse
//  mem_rdata        in   DATA_W         memory read data, valid with mem_resp
//  busy             out  1              high in BUSY state
//  grant_id         out  $clog2(NUM_CH) currently/last granted channel
// BEHAVIOUR
//  - FSM: IDLE, BUSY. Reset -> IDLE; all outputs 0; rr pointer = 0; grant_id = 0.
//  - IDLE: req_k = ch_read[k] | ch_write[k]. If any req, pick winner, register its read/write/
//    byte_enable/address/wdata into output regs, grant_id <= winner, go BUSY. Else stay, outputs 0.
//  - Fixed mode: lowest requesting index wins. RR mode: first requester at or after rr pointer
//    (wrapping NUM_CH-1 -> 0); on grant, pointer <= (winner+1) mod NUM_CH.
//  - ch_read & ch_write both high on one channel: treated as write (mem_write=1, mem_read=0).
//  - BUSY: mem_* outputs are the registered copy, stable regardless of channel inputs changing.
//    On mem_resp: ch_resp[grant_id]=1 and ch_rdata=mem_rdata combinationally same cycle;
//    next cycle -> IDLE with mem_read/mem_write = 0.
//  - mem_read and mem_write never both high; never high in IDLE.
//  - Latency: req sampled in IDLE cycle t -> mem strobe high at t+1. mem_resp at cycle r ->
//    ch_resp at r, strobes low at r+1, next grant strobes visible r+2 earliest.
//  - A channel still asserting its request in the cycle after its ch_resp is a new request.
//  - mem_resp while IDLE: ignored, no ch_resp pulse.
//  - ch_rdata = mem_rdata at all times (don't-care unless ch_resp high); ch_resp = 0 outside BUSY.
//  - rst mid-transaction (BUSY): -> IDLE, strobes drop next edge, rr pointer = 0; late mem_resp ignored.
//  - Non-granted channels see ch_resp=0 and stall; no request is dropped, only deferred.
// TESTING
//  1. Single read: ch0 read addr 0x100, mem_resp 2 cycles after strobe, rdata 0xDEADBEEF ->
//     mem_read high 1 cycle after req; ch_resp=2'b01 with ch_rdata 0xDEADBEEF; strobe low next cycle.
//  2. Fixed priority: ARB_MODE=0, ch0 and ch1 request continuously for 4 transactions ->
//     every grant_id=0; ch1 never receives ch_resp.
//  3. Round-robin: ARB_MODE=1, NUM_CH=4, all 4 request continuously -> grant order 0,1,2,3,0,
//     with pointer wrap from 3 to 0.
//  4. Write path: ch1 write addr 0x2004, be 4'b0011, wdata 0x0000ABCD -> mem_write=1,
//     mem_read=0, mem_byte_enable=4'b0011, values held stable while ch1 inputs change in BUSY.
//  5. Reset mid-op: rst asserted while BUSY before mem_resp -> next cycle IDLE, all outputs 0;
//     mem_resp pulsed afterwards produces no ch_resp.
//  6. Stray/both: mem_resp in IDLE -> no ch_resp; ch0 read+write both high -> mem_write only.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RV32I-style memory port between NUM_CH requesters.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no transaction open; sample requests, pick a winner
//   BUSY  | winner's command held on mem_*; wait for mem_resp pulse
//
// ARB_MODE 0 = fixed priority (lowest index wins), 1 = round-robin.
module mem_port_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0,
    localparam int BE_W    = DATA_W / 8,
    localparam int GID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*BE_W-1:0]   ch_byte_enable,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [BE_W-1:0]          mem_byte_enable,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_resp,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     busy,
    output logic [GID_W-1:0]         grant_id
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_n;
    logic                rd_q, rd_n;
    logic                wr_q, wr_n;
    logic [BE_W-1:0]     be_q, be_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [DATA_W-1:0]   wdata_q, wdata_n;
    logic [GID_W-1:0]    gid_q, gid_n;
    logic [GID_W-1:0]    rr_ptr_q, rr_ptr_n;

    logic [NUM_CH-1:0]   req;
    logic                any_req;
    logic [GID_W-1:0]    winner;
    logic                found;
    int                  idx;

    // Winner selection among current requesters (fixed or round-robin).
    always_comb begin
        req     = ch_read | ch_write;
        any_req = |req;
        winner  = '0;
        found   = 1'b0;
        idx     = 0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (req[i]) winner = GID_W'(i);
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                if (!found && req[idx]) begin
                    found  = 1'b1;
                    winner = GID_W'(idx);
                end
            end
        end
    end

    // Next-state and next registered command for the memory port.
    always_comb begin
        state_n  = state_q;
        rd_n     = rd_q;
        wr_n     = wr_q;
        be_n     = be_q;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        gid_n    = gid_q;
        rr_ptr_n = rr_ptr_q;
        case (state_q)
            IDLE: begin
                rd_n    = 1'b0;
                wr_n    = 1'b0;
                be_n    = '0;
                addr_n  = '0;
                wdata_n = '0;
                if (any_req) begin
                    state_n = BUSY;
                    // Read and write together on one channel is a write.
                    wr_n    = ch_write[winner];
                    rd_n    = ~ch_write[winner];
                    be_n    = ch_byte_enable[int'(winner)*BE_W +: BE_W];
                    addr_n  = ch_address[int'(winner)*ADDR_W +: ADDR_W];
                    wdata_n = ch_wdata[int'(winner)*DATA_W +: DATA_W];
                    gid_n   = winner;
                    if (ARB_MODE != 0) begin
                        rr_ptr_n = (winner == GID_W'(NUM_CH - 1)) ? '0 : winner + GID_W'(1);
                    end
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    state_n = IDLE;
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    be_n    = '0;
                    addr_n  = '0;
                    wdata_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and command registers; reset clears everything including the rr pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gid_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_n;
            rd_q     <= rd_n;
            wr_q     <= wr_n;
            be_q     <= be_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            gid_q    <= gid_n;
            rr_ptr_q <= rr_ptr_n;
        end
    end

    // Completion pulse routed to the granted channel only while a transaction is open.
    always_comb begin
        ch_resp = '0;
        if (state_q == BUSY && mem_resp) ch_resp[gid_q] = 1'b1;
    end

    assign ch_rdata        = mem_rdata;
    assign mem_read        = rd_q;
    assign mem_write       = wr_q;
    assign mem_byte_enable = be_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = wdata_q;
    assign busy            = (state_q == BUSY);
    assign grant_id        = gid_q;

endmodule
